// File: rtl/crc_stream_engine.sv
// crc_stream_engine: bit-serial CRC engine sitting between the UART receiver
// and transmitter. Bytes are folded into the CRC one bit per cycle; the
// finalised CRC is emitted either after every byte (MODE=0) or once per frame
// (MODE=1) and is serialised MSB-byte first to the transmitter, with
// back-pressure on tx_busy.
// Optional build macro: CRC_TIMEOUT_EN adds an idle counter that closes an
// open frame after TIMEOUT_CYC cycles without input.
module crc_stream_engine #(
  parameter int unsigned      CRC_W       = 8,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'('h07),
  parameter logic [CRC_W-1:0] INIT        = '0,
  parameter logic [CRC_W-1:0] XOROUT      = '0,
  parameter bit               REFIN       = 1'b0,
  parameter bit               REFOUT      = 1'b0,
  parameter bit               MODE        = 1'b0,
  parameter int unsigned      TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_en,
  input  logic             frame_end,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_data_en,
  output logic [CRC_W-1:0] crc_value,
  output logic             crc_valid,
  output logic             overrun
);

  localparam int unsigned NBYTES = CRC_W / 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_FINAL = 3'd2,
    S_SEND  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // Reject unsupported widths and a zero timeout at elaboration time
  if (!(CRC_W == 8 || CRC_W == 16 || CRC_W == 32) || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("crc_stream_engine: CRC_W must be 8/16/32 and TIMEOUT_CYC nonzero");
  end

  function automatic logic [CRC_W-1:0] bit_reverse(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CRC_W); i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic             din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return (crc << 1) ^ (fb ? POLY : '0);
  endfunction

  state_t                 state;
  logic [CRC_W-1:0]       crc_reg;
  logic [7:0]             buf_data;
  logic                   buf_full;
  logic                   pending_end;
  logic                   final_on_end;
  logic [7:0]             shreg;
  logic [BIT_W-1:0]       bit_cnt;
  logic [IDX_W-1:0]       byte_idx;
  logic                   guard;
  logic                   pop;
  logic                   in_bit;
  logic                   timeout_hit;
  logic [CRC_W-1:0]       result_c;

  assign pop      = (state == S_IDLE) && buf_full;
  assign in_bit   = REFIN ? shreg[0] : shreg[7];
  assign result_c = (REFOUT ? bit_reverse(crc_reg) : crc_reg) ^ XOROUT;

`ifdef CRC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            frame_open;

  assign timeout_hit = frame_open && !rx_data_en && !frame_end &&
                       (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle counter: runs while a frame is open, parks at TIMEOUT_CYC once it fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt   <= '0;
      frame_open <= 1'b0;
    end else if (frame_end) begin
      frame_open <= 1'b0;
      if (rx_data_en) idle_cnt <= '0;
    end else if (rx_data_en) begin
      idle_cnt   <= '0;
      frame_open <= 1'b1;
    end else if (frame_open) begin
      if (timeout_hit) begin
        idle_cnt   <= TO_W'(TIMEOUT_CYC);
        frame_open <= 1'b0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Holding buffer, frame-close flag and the CRC/serialiser state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      crc_reg      <= INIT;
      buf_data     <= '0;
      buf_full     <= 1'b0;
      pending_end  <= 1'b0;
      final_on_end <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      byte_idx     <= '0;
      guard        <= 1'b0;
      tx_data      <= '0;
      tx_data_en   <= 1'b0;
      crc_value    <= '0;
      crc_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      tx_data_en <= 1'b0;
      crc_valid  <= 1'b0;
      overrun    <= 1'b0;

      // A slot freed by this cycle's pop can take the incoming byte
      if (rx_data_en) begin
        if (!buf_full || pop) begin
          buf_data <= rx_data;
          buf_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pop) begin
        buf_full <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (buf_full) begin
            shreg   <= buf_data;
            bit_cnt <= '0;
            state   <= S_CALC;
          end else if (pending_end) begin
            final_on_end <= 1'b1;
            state        <= S_FINAL;
          end
        end

        S_CALC: begin
          crc_reg <= crc_step(crc_reg, in_bit);
          shreg   <= REFIN ? (shreg >> 1) : (shreg << 1);
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(7)) begin
            if (MODE) begin
              state <= S_IDLE;
            end else begin
              final_on_end <= 1'b0;
              state        <= S_FINAL;
            end
          end
        end

        S_FINAL: begin
          if (final_on_end) begin
            crc_reg     <= INIT;
            pending_end <= 1'b0;
          end
          // Running mode close with no byte only clears the register
          if (final_on_end && !MODE) begin
            state <= S_IDLE;
          end else begin
            crc_value <= result_c;
            crc_valid <= 1'b1;
            byte_idx  <= IDX_W'(NBYTES - 1);
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (!tx_busy) begin
            tx_data    <= 8'(crc_value >> {byte_idx, 3'b000});
            tx_data_en <= 1'b1;
            guard      <= 1'b1;
            state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Guard cycle gives the transmitter time to raise tx_busy
          if (guard) begin
            guard <= 1'b0;
          end else if (!tx_busy) begin
            if (byte_idx == '0) begin
              state <= S_IDLE;
            end else begin
              byte_idx <= byte_idx - IDX_W'(1);
              state    <= S_SEND;
            end
          end
        end

        default: state <= S_IDLE;
      endcase

      // A new close request outranks the clear of the previous one
      if (frame_end || timeout_hit) pending_end <= 1'b1;
    end
  end

endmodule
